sys_input_buffer: RTL and testbench

Input-side feeder for the 3-row systolic array. Holds one weight/activation tile of ROWS × DEPTH words, and on each cycle `read` is high it issues the next column. The column is skewed diagonally: row r lags row 0 by r cycles, so operands arrive wavefront-aligned at the processing elements. Each row has a per-lane valid strobe.

---
 rtl/input_buffer_pkg.sv | 18 +
 rtl/sys_input_buffer_if.sv | 13 +
 rtl/sys_input_buffer_skew_pipe.sv | 34 +++
 rtl/sys_input_buffer.sv | 68 ++++++
 tb/tb_sys_input_buffer.sv | 131 +++++++++++++
 5 files changed

// File: rtl/input_buffer_pkg.sv
// Shared constants and the default tile pattern for the systolic input buffer.
// The pattern is also used by the bench to build expected values.
package input_buffer_pkg;

  localparam int DEF_BITWIDTH = 8;
  localparam int DEF_ROWS     = 3;
  localparam int DEF_DEPTH    = 4;

  // Reset contents: (r*depth + k + 1) mod 2^bitwidth
  function automatic int unsigned default_word(input int r, input int k,
                                               input int depth, input int bitwidth);
    int unsigned v;
    v = int'(r * depth + k + 1);
    if (bitwidth < 32) v = v & ((32'd1 << bitwidth) - 32'd1);
    return v;
  endfunction

endpackage

// File: rtl/sys_input_buffer_if.sv
// Read request and per-lane skewed output bus of the systolic input buffer.
// read is a plain request with no ready: every read is accepted, and each lane's o_valid marks one word in o_data.
interface sys_input_buffer_if #(
  parameter int BITWIDTH = 8,
  parameter int ROWS     = 3
);
  logic                               read;
  logic [ROWS-1:0]                    o_valid;
  logic [ROWS-1:0][BITWIDTH-1:0]      o_data;

  modport master (output read, input o_valid, input o_data);
  modport slave  (input read, output o_valid, output o_data);
endinterface

// File: rtl/sys_input_buffer_skew_pipe.sv
// Valid+data delay line of STAGES registers; data is forced to zero while invalid.
module skew_pipe #(
  parameter int STAGES = 1,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int s = 0; s < STAGES; s++) r_data[s] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_valid ? i_data : '0;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign o_valid = r_valid[STAGES-1];
  assign o_data  = r_data[STAGES-1];

endmodule

// File: rtl/sys_input_buffer.sv
// Systolic input feeder: issues one column per read, row r delayed by r extra cycles.
// Optional INPUT_BUFFER_MEMINIT_EN loads the tile once at elaboration instead of on every reset.
module sys_input_buffer
  import input_buffer_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH,
  parameter int ROWS     = DEF_ROWS,
  parameter int DEPTH    = DEF_DEPTH
`ifdef INPUT_BUFFER_MEMINIT_EN
  ,
  parameter string INIT_FILE = "input_buffer_init.hex"
`endif
) (
  input  logic               clk,
  input  logic               rst,
  sys_input_buffer_if.slave  bus
);

  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BITWIDTH-1:0]           r_mem [ROWS][DEPTH];
  logic [CW-1:0]                 r_col;
  logic [ROWS-1:0]               w_valid;
  logic [ROWS-1:0][BITWIDTH-1:0] w_data;

`ifdef INPUT_BUFFER_MEMINIT_EN
  // Contents persist across reset; only the pointer and pipes are cleared.
  initial begin
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < DEPTH; k++)
        r_mem[r][k] = BITWIDTH'(default_word(r, k, DEPTH, BITWIDTH));
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int k = 0; k < DEPTH; k++)
          r_mem[r][k] <= BITWIDTH'(default_word(r, k, DEPTH, BITWIDTH));
    end
  end
`endif

  // Pointer persists between bursts and wraps silently.
  always_ff @(posedge clk) begin
    if (rst)
      r_col <= '0;
    else if (bus.read)
      r_col <= (r_col == CW'(DEPTH - 1)) ? '0 : r_col + CW'(1);
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_lane
    skew_pipe #(
      .STAGES (g + 1),
      .WIDTH  (BITWIDTH)
    ) u_pipe (
      .clk     (clk),
      .rst     (rst),
      .i_valid (bus.read),
      .i_data  (r_mem[g][r_col]),
      .o_valid (w_valid[g]),
      .o_data  (w_data[g])
    );
  end

  assign bus.o_valid = w_valid;
  assign bus.o_data  = w_data;

endmodule

// File: tb/tb_sys_input_buffer.sv
// Scoreboard bench for sys_input_buffer: each driven cycle queues the outputs expected after its edge.
module tb_sys_input_buffer;
  import input_buffer_pkg::*;

  localparam int BW = 8;
  localparam int NR = 3;
  localparam int ND = 4;
  localparam int W  = NR + NR * BW;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sys_input_buffer_if #(.BITWIDTH(BW), .ROWS(NR)) bus ();

  sys_input_buffer #(.BITWIDTH(BW), .ROWS(NR), .DEPTH(ND)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           checks  = 0;
  int           errors  = 0;
  int           step_id = 0;

  // drive one cycle; expected {valid[2:0], d2, d1, d0} is what the outputs show after the edge
  task automatic step(input logic r, input logic rd, input logic [2:0] v,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    @(negedge clk);
    rst      = r;
    bus.read = rd;
    exp_q.push_back({v, d2, d1, d0});
    id_q.push_back(step_id);
    step_id++;
  endtask

  // monitor
  initial begin
    logic [W-1:0] e;
    int           id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        id = id_q.pop_front();
        checks++;
        if ({bus.o_valid, bus.o_data} !== e) begin
          errors++;
          $display("FAIL out_step%0d: got valid=%b data=%h, expected valid=%b data=%h",
                   id, bus.o_valid, bus.o_data, e[W-1 -: NR], e[NR*BW-1:0]);
        end
      end
    end
  end

  initial begin
    logic [2:0] v;
    logic [7:0] dd [NR];
    int         k;
    rst      = 1'b1;
    bus.read = 1'b0;

    // 1: reset, then idle
    step(1, 0, 3'b000, 0, 0, 0);
    step(1, 0, 3'b000, 0, 0, 0);
    step(0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 3'b000, 0, 0, 0);

    // 2: three-cycle burst from col 0
    step(0, 1, 3'b001, 1, 0, 0);
    step(0, 1, 3'b011, 2, 5, 0);
    step(0, 1, 3'b111, 3, 6, 9);
    step(0, 0, 3'b110, 0, 7, 10);
    step(0, 0, 3'b100, 0, 0, 11);
    step(0, 0, 3'b000, 0, 0, 0);
    step(0, 0, 3'b000, 0, 0, 0);

    // 3: continuation from col 3, wraps to col 0
    step(0, 1, 3'b001, 4, 0, 0);
    step(0, 1, 3'b011, 1, 8, 0);
    step(0, 0, 3'b110, 0, 5, 12);
    step(0, 0, 3'b100, 0, 0, 9);
    step(0, 0, 3'b000, 0, 0, 0);

    // 4: nine back-to-back reads from reset
    step(1, 0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < NR; r++) begin
        k = i - r;
        v[r]  = (k >= 0 && k < 9);
        dd[r] = v[r] ? BW'(default_word(r, k % ND, ND, BW)) : 8'd0;
      end
      step(0, (i < 9), v, dd[0], dd[1], dd[2]);
    end

    // 5: mid-stream reset (pointer starts at 1 here)
    step(0, 1, 3'b001, 2, 0, 0);
    step(0, 1, 3'b011, 3, 6, 0);
    step(1, 1, 3'b000, 0, 0, 0);
    step(0, 1, 3'b001, 1, 0, 0);
    step(0, 0, 3'b010, 0, 5, 0);
    step(0, 0, 3'b100, 0, 0, 9);
    step(0, 0, 3'b000, 0, 0, 0);

    // 6: read pattern 1,0,1
    step(1, 0, 3'b000, 0, 0, 0);
    step(0, 1, 3'b001, 1, 0, 0);
    step(0, 0, 3'b010, 0, 5, 0);
    step(0, 1, 3'b101, 2, 0, 9);
    step(0, 0, 3'b010, 0, 6, 0);
    step(0, 0, 3'b100, 0, 0, 10);
    step(0, 0, 3'b000, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
